// File: rtl/fas_pkg.sv
// Shared types and constants for the frequency-analysis chain.
// Word sizes, FSM states, complex sample struct and forward W16 ROM.
package fas_pkg;

  localparam int DW   = 32;
  localparam int FRAC = 16;

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    UNLOAD
  } state_t;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  // Forward twiddles W16^k, Q16.16; conjugated in the butterfly.
  localparam cplx_t TW [8] = '{
    '{re:  32'sd65536, im:  32'sd0},
    '{re:  32'sd60547, im: -32'sd25080},
    '{re:  32'sd46341, im: -32'sd46341},
    '{re:  32'sd25080, im: -32'sd60547},
    '{re:  32'sd0,     im: -32'sd65536},
    '{re: -32'sd25080, im: -32'sd60547},
    '{re: -32'sd46341, im: -32'sd46341},
    '{re: -32'sd60547, im: -32'sd25080}
  };

endpackage

// File: rtl/ifft_bfly.sv
// Registered inverse DIT butterfly, latency 1.
// Ports: clk; x, y, w in; a_out=(x+t)>>>1, b_out=(x-t)>>>1, t=conj(w)*y.
module ifft_bfly
  import fas_pkg::*;
(
  input  logic  clk,
  input  cplx_t x,
  input  cplx_t y,
  input  cplx_t w,
  output cplx_t a_out,
  output cplx_t b_out
);

  logic signed [2*DW-1:0] yr, yi, wr, wi;
  logic signed [2*DW-1:0] pr, pi;
  logic signed [DW-1:0]   tr, ti;
  logic signed [DW:0]     xr, xi;
  logic signed [DW:0]     sr, si, dr, di;

  always_comb begin
    yr = (2*DW)'($signed(y.re));
    yi = (2*DW)'($signed(y.im));
    wr = (2*DW)'($signed(w.re));
    wi = (2*DW)'($signed(w.im));
    pr = yr * wr + yi * wi;
    pi = yi * wr - yr * wi;
    // truncating slice [FRAC+DW-1:FRAC]
    tr = DW'(pr >>> FRAC);
    ti = DW'(pi >>> FRAC);
    // one guard bit so the halving never overflows
    xr = (DW+1)'($signed(x.re));
    xi = (DW+1)'($signed(x.im));
    sr = xr + (DW+1)'(tr);
    si = xi + (DW+1)'(ti);
    dr = xr - (DW+1)'(tr);
    di = xi - (DW+1)'(ti);
  end

  always_ff @(posedge clk) begin
    a_out.re <= DW'(sr >>> 1);
    a_out.im <= DW'(si >>> 1);
    b_out.re <= DW'(dr >>> 1);
    b_out.im <= DW'(di >>> 1);
  end

endmodule

// File: rtl/ifft16_core.sv
// 16-point radix-2 DIT inverse FFT, bit-reversed in, natural out, 1/16.
// Ports: clk, rst; in_valid/in_ready/in_re/in_im; out_* stream; busy.
module ifft16_core
  import fas_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic          out_last,
  output logic          busy
);

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] ucnt;
  logic [1:0] stg;
  logic [3:0] slot;
  cplx_t      bufm [16];

  logic [3:0] half, pos, jj, top, bot;
  logic [2:0] k;
  logic       issue;
  logic       wv;
  logic [3:0] wtop, wbot;
  cplx_t      a, b;

  always_comb begin
    jj    = {1'b0, slot[2:0]};
    half  = 4'd1 << stg;
    pos   = jj & (half - 4'd1);
    top   = ((jj >> stg) << ({1'b0, stg} + 3'd1)) + pos;
    bot   = top + half;
    k     = 3'(pos << (2'd3 - stg));
    issue = (state == COMPUTE) && !slot[3];
  end

  ifft_bfly u_bfly (
    .clk   (clk),
    .x     (bufm[top]),
    .y     (bufm[bot]),
    .w     (TW[k]),
    .a_out (a),
    .b_out (b)
  );

  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid && in_ready)
      bufm[cnt] <= '{re: in_re, im: in_im};
    if (wv) begin
      bufm[wtop] <= a;
      bufm[wbot] <= b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= '0;
      ucnt      <= '0;
      stg       <= '0;
      slot      <= '0;
      wv        <= 1'b0;
      wtop      <= '0;
      wbot      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      busy      <= 1'b0;
    end else begin
      wv   <= issue;
      wtop <= top;
      wbot <= bot;
      unique case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              state    <= COMPUTE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              stg      <= '0;
              slot     <= '0;
            end
          end
        end
        COMPUTE: begin
          // slot 8 is the inter-stage bubble
          if (slot == 4'd8) begin
            slot <= '0;
            stg  <= stg + 2'd1;
            if (stg == 2'd3)
              state <= UNLOAD;
          end else begin
            slot <= slot + 4'd1;
          end
        end
        UNLOAD: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_re    <= bufm[0].re;
            out_im    <= bufm[0].im;
            out_last  <= 1'b0;
            ucnt      <= '0;
          end else if (out_ready) begin
            if (ucnt == 4'd15) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= LOAD;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              ucnt     <= ucnt + 4'd1;
              out_re   <= bufm[ucnt + 4'd1].re;
              out_im   <= bufm[ucnt + 4'd1].im;
              out_last <= (ucnt == 4'd14);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ifft16_core.sv
// Bench for ifft16_core: random and directed frames vs a direct IDFT.
// Checks handshakes, latency, backpressure hold, busy gap and reset.
module tb_ifft16_core;
  import fas_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_re, in_im;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_re, out_im;
  logic          out_last;
  logic          busy;

  ifft16_core dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  logic signed [DW-1:0] fr_re [16];
  logic signed [DW-1:0] fr_im [16];
  longint exp_re [16], exp_im [16];
  longint got_re [16], got_im [16];
  int     got_last [16];
  int     n_got;
  int     last_acc, first_val;

  task automatic chk(string tag, longint obs,
                     longint want, longint tol);
    n_chk++;
    if (obs - want > tol || want - obs > tol)
      $display("FAIL %s: got %0d, want %0d (tol %0d)",
               tag, obs, want, tol);
    else
      n_pass++;
  endtask

  function automatic int brev(input int v);
    logic [3:0] q;
    q = v[3:0];
    return int'({q[0], q[1], q[2], q[3]});
  endfunction

  // Direct IDFT: bin kk sits in slot brev(kk); scale 1/16.
  task automatic model();
    real pi2, ar, ai, xr, xi, ang;
    pi2 = 2.0 * 3.141592653589793;
    for (int n = 0; n < 16; n++) begin
      ar = 0.0;
      ai = 0.0;
      for (int kk = 0; kk < 16; kk++) begin
        xr  = real'(int'(fr_re[brev(kk)]));
        xi  = real'(int'(fr_im[brev(kk)]));
        ang = pi2 * real'(kk * n) / 16.0;
        ar  = ar + xr * $cos(ang) - xi * $sin(ang);
        ai  = ai + xr * $sin(ang) + xi * $cos(ang);
      end
      exp_re[n] = longint'(ar / 16.0);
      exp_im[n] = longint'(ai / 16.0);
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 16; i++) begin
      fr_re[i] = '0;
      fr_im[i] = '0;
    end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 16; i++) begin
      fr_re[i] = int'($urandom_range(524287, 0)) - 262144;
      fr_im[i] = int'($urandom_range(524287, 0)) - 262144;
    end
  endtask

  // Called at a negedge; returns at the negedge after the last accept.
  task automatic send_frame(input bit keep);
    int  i = 0;
    int  g = 0;
    bit  acc;
    in_valid = 1'b1;
    while (i < 16 && g < 300) begin
      in_re = fr_re[i];
      in_im = fr_im[i];
      acc   = in_ready;
      @(negedge clk);
      g++;
      if (acc) i++;
    end
    last_acc = cyc;
    if (!keep) in_valid = 1'b0;
    chk("load_count", i, 16, 0);
  endtask

  task automatic collect(input bit bp, input longint tol);
    int g = 0;
    int stall = 0;
    n_got = 0;
    first_val = -1;
    while (n_got < 16 && g < 400) begin
      if (out_valid && first_val < 0) first_val = cyc;
      if (bp && out_valid && n_got == 7 && stall < 5) begin
        out_ready = 1'b0;
        stall++;
        chk("hold_re", longint'($signed(out_re)), exp_re[7], tol);
        chk("hold_im", longint'($signed(out_im)), exp_im[7], tol);
        chk("hold_last", longint'(out_last), 0, 0);
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        got_re[n_got]   = longint'($signed(out_re));
        got_im[n_got]   = longint'($signed(out_im));
        got_last[n_got] = int'(out_last);
        n_got++;
      end
      @(negedge clk);
      g++;
    end
    out_ready = 1'b1;
    chk("beats", n_got, 16, 0);
    chk("latency", first_val - last_acc, 37, 0);
    chk("valid_drop", longint'(out_valid), 0, 0);
    chk("ready_back", longint'(in_ready), 1, 0);
    if (bp) chk("stall_cycles", stall, 5, 0);
    for (int n = 0; n < 16; n++) begin
      chk($sformatf("re[%0d]", n), got_re[n], exp_re[n], tol);
      chk($sformatf("im[%0d]", n), got_im[n], exp_im[n], tol);
      chk($sformatf("last[%0d]", n), got_last[n],
          (n == 15) ? 1 : 0, 0);
    end
  endtask

  task automatic run_frame(input bit bp, input longint tol);
    model();
    send_frame(1'b0);
    collect(bp, tol);
  endtask

  initial begin
    int gap;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 0, 0);
    chk("rst_out_valid", longint'(out_valid), 0, 0);
    chk("rst_out_last", longint'(out_last), 0, 0);
    chk("rst_out_re", longint'(out_re), 0, 0);
    chk("rst_out_im", longint'(out_im), 0, 0);
    chk("rst_busy", longint'(busy), 0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready_up", longint'(in_ready), 1, 0);

    clear_frame();
    fr_re[0] = 32'sh0010_0000;
    run_frame(1'b0, 1);
    chk("dc_out0_re", got_re[0], 65536, 1);

    clear_frame();
    fr_re[8] = 32'sd16 <<< 16;
    run_frame(1'b0, 2);
    chk("tone_out4_re", got_re[4], 0, 2);
    chk("tone_out4_im", got_im[4], 65536, 2);

    rand_frame();
    run_frame(1'b0, 4);
    rand_frame();
    run_frame(1'b1, 4);

    // busy guard: in_valid held high across two frames
    rand_frame();
    model();
    send_frame(1'b1);
    gap = 0;
    fork
      collect(1'b0, 4);
      begin
        while (!in_ready && gap < 200) begin
          if (gap == 10) chk("busy_mid", longint'(busy), 1, 0);
          gap++;
          @(negedge clk);
        end
      end
    join
    chk("ready_gap", gap, 53, 0);
    chk("busy_done", longint'(busy), 0, 0);
    rand_frame();
    run_frame(1'b0, 4);

    // reset during stage 2 of compute
    rand_frame();
    send_frame(1'b0);
    repeat (20) @(negedge clk);
    chk("pre_rst_busy", longint'(busy), 1, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", longint'(out_valid), 0, 0);
    chk("mid_rst_busy", longint'(busy), 0, 0);
    chk("mid_rst_ready", longint'(in_ready), 0, 0);
    @(negedge clk);
    chk("mid_rst_ready_up", longint'(in_ready), 1, 0);
    clear_frame();
    fr_re[0] = 32'sh0010_0000;
    run_frame(1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
